// File: rtl/avalon_mmio_pkg.sv
// Register offsets, write FSM states and byte-lane merge shared by the MMIO responder.
package avalon_mmio_pkg;

   localparam int unsigned OFF_LED   = 'h00;
   localparam int unsigned OFF_HEX   = 'h20;
   localparam int unsigned OFF_COUNT = 'h40;
   localparam int unsigned OFF_CMP   = 'h41;
   localparam int unsigned OFF_CTRL  = 'h42;

   typedef enum logic {IDLE, WACK} wr_state_t;

   function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/read_latency_pipe.sv
// Fixed-depth valid/data shift register; reset empties it so in-flight reads are dropped.
module read_latency_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid;
         data_q[0]  <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/avalon_mmio_responder.sv
// Avalon-MM responder: LED/HEX registers and a compare timer driving irq.
// Define AVMM_RESP_TRACE_EN to print committed writes and unmapped reads.
module avalon_mmio_responder
   import avalon_mmio_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH   = 29,
   parameter logic [ADDR_WIDTH-1:0] BASE_WORD    = 29'h1000000,
   parameter int unsigned           READ_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] avs_address,
   input  logic [3:0]            avs_byteenable,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [31:0]           avs_writedata,
   output logic [31:0]           avs_readdata,
   output logic                  avs_readdatavalid,
   output logic                  avs_waitrequest,
   output logic [31:0]           led_out,
   output logic [31:0]           hex_out,
   output logic                  irq
);

   wr_state_t             state;
   logic [31:0]           led_q, hex_q, count_q, count_d, cmp_q, cmp_d, rd_data;
   logic                  ie_q, pend_q, pend_d, pend_clr;
   logic [ADDR_WIDTH-1:0] offset;
   logic                  in_window, wr_commit, rd_accept;
   logic                  hit_led, hit_hex, hit_count, hit_cmp, hit_ctrl;

   assign in_window = (avs_address >= BASE_WORD);
   assign offset    = avs_address - BASE_WORD;
   assign hit_led   = in_window && (offset == ADDR_WIDTH'(OFF_LED));
   assign hit_hex   = in_window && (offset == ADDR_WIDTH'(OFF_HEX));
   assign hit_count = in_window && (offset == ADDR_WIDTH'(OFF_COUNT));
   assign hit_cmp   = in_window && (offset == ADDR_WIDTH'(OFF_CMP));
   assign hit_ctrl  = in_window && (offset == ADDR_WIDTH'(OFF_CTRL));

   // A held write is accepted in WACK; anything else presented in WACK stalls.
   assign avs_waitrequest = (state == IDLE) ? avs_write : !avs_write;
   assign wr_commit       = (state == WACK) && avs_write;
   assign rd_accept       = (state == IDLE) && avs_read && !avs_write;

   always_comb begin
      count_d  = count_q + 32'd1;
      cmp_d    = cmp_q;
      if (wr_commit && hit_count) count_d = apply_be(count_q, avs_writedata, avs_byteenable);
      if (wr_commit && hit_cmp)   cmp_d   = apply_be(cmp_q, avs_writedata, avs_byteenable);
      pend_clr = wr_commit && hit_ctrl && avs_byteenable[0] && avs_writedata[1];
      // Match on next-state values so pend is high in the same cycle COUNT==CMP.
      pend_d   = (count_d == cmp_d) || (pend_q && !pend_clr);
   end

   always_comb begin
      rd_data = '0;
      if (hit_led)   rd_data = led_q;
      if (hit_hex)   rd_data = hex_q;
      if (hit_count) rd_data = count_q;
      if (hit_cmp)   rd_data = cmp_q;
      if (hit_ctrl)  rd_data = {30'd0, pend_q, ie_q};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         led_q   <= '0;
         hex_q   <= '0;
         count_q <= '0;
         cmp_q   <= '1;
         ie_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         cmp_q   <= cmp_d;
         pend_q  <= pend_d;
         if (wr_commit && hit_led) led_q <= apply_be(led_q, avs_writedata, avs_byteenable);
         if (wr_commit && hit_hex) hex_q <= apply_be(hex_q, avs_writedata, avs_byteenable);
         if (wr_commit && hit_ctrl && avs_byteenable[0]) ie_q <= avs_writedata[0];
         case (state)
            IDLE:    if (avs_write) state <= WACK;
            WACK:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   read_latency_pipe #(
      .WIDTH (32),
      .DEPTH (READ_LATENCY)
   ) u_rd_pipe (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (rd_accept),
      .in_data   (rd_accept ? rd_data : 32'd0),
      .out_valid (avs_readdatavalid),
      .out_data  (avs_readdata)
   );

   assign led_out = led_q;
   assign hex_out = hex_q;
   assign irq     = ie_q && pend_q;

`ifdef AVMM_RESP_TRACE_EN
   logic rd_mapped;
   assign rd_mapped = hit_led || hit_hex || hit_count || hit_cmp || hit_ctrl;

   always_ff @(posedge clock) begin
      if (reset_n && wr_commit)
         $display("MMIO write, address %h, data %h, be %b", {avs_address, 2'b00},
                  avs_writedata, avs_byteenable);
      if (reset_n && rd_accept && !rd_mapped)
         $display("MMIO unmapped read %h", {avs_address, 2'b00});
   end
`endif

endmodule

// File: tb/tb_avalon_mmio_responder.sv
// Directed bench for avalon_mmio_responder: reset, byte-lane writes, pipelined reads, timer irq.
module tb_avalon_mmio_responder;

   localparam logic [28:0] BASE = 29'h1000000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [28:0] avs_address = '0;
   logic [3:0]  avs_byteenable = '0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata, led_out, hex_out;
   logic        avs_readdatavalid, avs_waitrequest, irq;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [28:0] rd_addr [8];
   logic [31:0] rd_exp [8];
   int          rd_cyc [8];

   avalon_mmio_responder u_dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .avs_address       (avs_address),
      .avs_byteenable    (avs_byteenable),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .avs_waitrequest   (avs_waitrequest),
      .led_out           (led_out),
      .hex_out           (hex_out),
      .irq               (irq)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the commit edge.
   task automatic mmio_write(input logic [28:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
      avs_write      = 1'b1;
      avs_address    = addr;
      avs_writedata  = data;
      avs_byteenable = be;
      #1 check("wr_wait_idle", avs_waitrequest, 1);
      @(posedge clock);
      @(negedge clock);
      check("wr_wait_wack", avs_waitrequest, 0);
      @(posedge clock);
      @(negedge clock);
      avs_write = 1'b0;
   endtask

   // Back-to-back reads of rd_addr[0..n-1]; each must return exactly two cycles after acceptance.
   task automatic read_burst(input int n);
      for (int k = 0; k < n + 2; k++) begin
         if (k < n) begin
            avs_read    = 1'b1;
            avs_address = rd_addr[k];
            rd_cyc[k]   = cyc;
         end else begin
            avs_read = 1'b0;
         end
         #1;
         check($sformatf("rd_wait_%0d", k), avs_waitrequest, 0);
         if (k >= 2) begin
            check($sformatf("rd_valid_%0d", k - 2), avs_readdatavalid, 1);
            check($sformatf("rd_data_%0d", k - 2), avs_readdata, rd_exp[k - 2]);
         end else begin
            check($sformatf("rd_valid_early_%0d", k), avs_readdatavalid, 0);
         end
         @(posedge clock);
         @(negedge clock);
      end
      #1 check("rd_valid_end", avs_readdatavalid, 0);
   endtask

   initial begin
      int waited;
      int sample;

      // 1: reset values, then read LED and CMP
      #1;
      check("rst_led", led_out, 0);
      check("rst_hex", hex_out, 0);
      check("rst_irq", irq, 0);
      check("rst_valid", avs_readdatavalid, 0);
      check("rst_wait", avs_waitrequest, 0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      rd_addr[0] = BASE;          rd_exp[0] = 32'h0;
      rd_addr[1] = BASE + 29'h41; rd_exp[1] = 32'hFFFF_FFFF;
      read_burst(2);

      // 2: byte-lane write to LED, full write to HEX, write outside the window ignored
      @(negedge clock);
      mmio_write(BASE, 32'hA5A5_A5A5, 4'b0011);
      check("led_be", led_out, 32'h0000_A5A5);
      mmio_write(BASE + 29'h20, 32'h1234_5678, 4'hF);
      check("hex_full", hex_out, 32'h1234_5678);
      mmio_write(29'h10, 32'hFFFF_FFFF, 4'hF);
      check("led_outside", led_out, 32'h0000_A5A5);

      // 3: pipelined reads including an unmapped offset and a below-window address
      rd_addr[0] = BASE;          rd_exp[0] = 32'h0000_A5A5;
      rd_addr[1] = BASE + 29'h20; rd_exp[1] = 32'h1234_5678;
      rd_addr[2] = BASE + 29'h7F; rd_exp[2] = 32'h0;
      rd_addr[3] = BASE + 29'h42; rd_exp[3] = 32'h0;
      rd_addr[4] = 29'h10;        rd_exp[4] = 32'h0;
      read_burst(5);

      // 4: COUNT load and pre-increment read, compare interrupt 10 cycles after the sample
      mmio_write(BASE + 29'h40, 32'd100, 4'hF);
      rd_addr[0] = BASE + 29'h40; rd_exp[0] = 32'd100;
      read_burst(1);
      sample = rd_cyc[0];
      mmio_write(BASE + 29'h41, 32'd110, 4'hF);
      mmio_write(BASE + 29'h42, 32'd1, 4'hF);
      waited = 0;
      while (!irq && waited < 50) begin
         @(posedge clock);
         @(negedge clock);
         waited++;
      end
      check("irq_rise", irq, 1);
      check("irq_delay", cyc - sample, 10);
      rd_addr[0] = BASE + 29'h42; rd_exp[0] = 32'd3;
      rd_addr[1] = BASE + 29'h41; rd_exp[1] = 32'd110;
      read_burst(2);
      mmio_write(BASE + 29'h42, 32'd2, 4'hF);
      check("irq_clear", irq, 0);
      rd_addr[0] = BASE + 29'h42; rd_exp[0] = 32'd0;
      read_burst(1);

      // 5: COUNT wrap onto CMP=0
      mmio_write(BASE + 29'h41, 32'd0, 4'hF);
      mmio_write(BASE + 29'h42, 32'd1, 4'hF);
      mmio_write(BASE + 29'h40, 32'hFFFF_FFFE, 4'hF);
      check("wrap_fe", irq, 0);
      @(posedge clock);
      @(negedge clock);
      check("wrap_ff", irq, 0);
      @(posedge clock);
      @(negedge clock);
      check("wrap_zero", irq, 1);
      rd_addr[0] = BASE + 29'h40; rd_exp[0] = 32'd0;
      read_burst(1);

      // 6: async reset with two reads in flight
      @(negedge clock);
      check("pre_rst_led", led_out, 32'h0000_A5A5);
      avs_read    = 1'b1;
      avs_address = BASE;
      @(posedge clock);
      @(negedge clock);
      avs_address = BASE + 29'h20;
      @(posedge clock);
      #2 reset_n = 1'b0;
      avs_read = 1'b0;
      #1;
      check("async_led", led_out, 0);
      check("async_hex", hex_out, 0);
      check("async_irq", irq, 0);
      check("async_valid", avs_readdatavalid, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check($sformatf("post_rst_valid_%0d", i), avs_readdatavalid, 0);
      end
      rd_addr[0] = BASE + 29'h41; rd_exp[0] = 32'hFFFF_FFFF;
      read_burst(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
